// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the unified memory port controller.
// The controller uses the slave view; requesters and the memory together use the master view.
interface mem_port_arbiter_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          halt;
  logic [DW-1:0] mem_rdata;

  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          createdump;
  logic [DW-1:0] rdata;
  logic          i_done;
  logic          d_done;
  logic          i_stall;
  logic          d_stall;
  logic          err;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, halt, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, createdump, rdata,
           i_done, d_done, i_stall, d_stall, err, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, halt, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, createdump, rdata,
           i_done, d_done, i_stall, d_stall, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto a single fixed-latency memory port,
// returns read data with a done pulse, and issues the end-of-run dump on halt.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_port_arbiter_if.slave        bus
);
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [2:0]       state_q,      state_d;
  logic             grant_q,      grant_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [AW-1:0]    addr_q,       addr_d;
  logic [DW-1:0]    wdata_q,      wdata_d;
  logic [DW-1:0]    rdata_q,      rdata_d;
  logic             mem_en_q,     mem_en_d;
  logic             mem_wr_q,     mem_wr_d;
  logic             createdump_q, createdump_d;
  logic             i_done_q,     i_done_d;
  logic             d_done_q,     d_done_d;
  logic             err_q,        err_d;

  logic [AW-1:0]    req_addr;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= GNT_I;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      createdump_q <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      createdump_q <= createdump_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      err_q        <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = 1'b0;
    createdump_d = 1'b0;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    err_d        = 1'b0;
    req_addr     = bus.d_req ? bus.d_addr : bus.i_addr;

    case (state_q)
      S_IDLE: begin
        // A pending data access must finish before the dump is issued
        if (bus.halt && !bus.d_req) begin
          createdump_d = 1'b1;
          state_d      = S_HALTED;
        end else if (bus.d_req || bus.i_req) begin
          grant_d = bus.d_req ? GNT_D : GNT_I;
          addr_d  = req_addr;
          wdata_d = bus.d_req ? bus.d_wdata : '0;
          if (req_addr[0]) begin
            err_d    = 1'b1;
            d_done_d = bus.d_req;
            i_done_d = !bus.d_req;
            state_d  = S_DONE;
          end else begin
            mem_en_d = 1'b1;
            mem_wr_d = bus.d_req && bus.d_wr;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = bus.mem_rdata;
          i_done_d = (grant_q == GNT_I);
          d_done_d = (grant_q == GNT_D);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.createdump = createdump_q;
  assign bus.rdata      = rdata_q;
  assign bus.i_done     = i_done_q;
  assign bus.d_done     = d_done_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.i_stall    = bus.i_req & ~i_done_q;
  assign bus.d_stall    = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level timing/data model with a fixed-latency memory.
module tb_mem_port_arbiter;
  localparam int unsigned LAT = 2;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks;
  int n_pass;

  logic [15:0] dev_mem [256];
  logic        rd_v    [LAT];
  logic [15:0] rd_d    [LAT];
  logic [15:0] ref_mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a} ^ 16'h3C3C;
  endfunction

  // Fixed-latency memory: read data is valid only LAT cycles after the mem_en cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) dev_mem[k] <= init_val(8'(k));
    end else if (bus.mem_en && bus.mem_wr) begin
      dev_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    rd_v[0] <= bus.mem_en && !bus.mem_wr;
    rd_d[0] <= dev_mem[bus.mem_addr[7:0]];
    for (int k = 1; k < LAT; k++) begin
      rd_v[k] <= rd_v[k-1];
      rd_d[k] <= rd_d[k-1];
    end
  end

  assign bus.mem_rdata = rd_v[LAT-1] ? rd_d[LAT-1] : 16'h5A5A;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.halt    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if ({bus.mem_en, bus.mem_wr, bus.createdump, bus.i_done, bus.d_done, bus.err,
         bus.busy, bus.i_stall, bus.d_stall} !== 9'b0)
      $display("FAIL reset_ctrl: got %b want 0", {bus.mem_en, bus.mem_wr, bus.createdump,
               bus.i_done, bus.d_done, bus.err, bus.busy, bus.i_stall, bus.d_stall});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 48'h0)
      $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.rdata});
    else n_pass++;
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0010;
    tick();
    tick();
    n_checks++;
    if ({bus.mem_en, bus.busy, bus.d_done} !== 3'b000)
      $display("FAIL reset_holds_req: got %b want 000", {bus.mem_en, bus.busy, bus.d_done});
    else n_pass++;
    bus.d_req = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read();
    logic [4:0] exp;
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) tick();
      exp = {c == 1, c == 4, 1'b0, 1'b0, (c >= 1 && c <= 4)};
      n_checks++;
      if ({bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy} !== exp)
        $display("FAIL fetch_ctrl c%0d: got %b want %b", c,
                 {bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy}, exp);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if ({bus.mem_wr, bus.mem_addr} !== {1'b0, 16'h0010})
          $display("FAIL fetch_addr: got %h want 0010", {bus.mem_wr, bus.mem_addr});
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (bus.rdata !== 16'hBEEF) $display("FAIL fetch_rdata: got %h want beef", bus.rdata);
        else n_pass++;
        bus.i_req = 1'b0;
      end
      #1;
      n_checks++;
      if (bus.i_stall !== (c <= 3))
        $display("FAIL fetch_stall c%0d: got %b want %b", c, bus.i_stall, (c <= 3));
      else n_pass++;
    end
  endtask

  task automatic test_data_write();
    logic [4:0] exp;
    do_reset();
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0020;
    bus.d_wdata = 16'h1234;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) tick();
      exp = {c == 1, 1'b0, c == 4, 1'b0, (c >= 1 && c <= 4)};
      n_checks++;
      if ({bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy} !== exp)
        $display("FAIL write_ctrl c%0d: got %b want %b", c,
                 {bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy}, exp);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if ({bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'h0020, 16'h1234})
          $display("FAIL write_port: got %b %h %h want 1 0020 1234",
                   bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
      end
      if (c == 4) begin
        bus.d_req = 1'b0;
        bus.d_wr  = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp;
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0030;
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0032;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) tick();
      exp = {(c == 1 || c == 6), c == 9, c == 4, 1'b0,
             ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))};
      n_checks++;
      if ({bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy} !== exp)
        $display("FAIL contend_ctrl c%0d: got %b want %b", c,
                 {bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy}, exp);
      else n_pass++;
      if (c == 1 || c == 6) begin
        n_checks++;
        if (bus.mem_addr !== ((c == 1) ? 16'h0032 : 16'h0030))
          $display("FAIL contend_addr c%0d: got %h", c, bus.mem_addr);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (bus.rdata !== init_val(8'h32))
          $display("FAIL contend_d_rdata: got %h want %h", bus.rdata, init_val(8'h32));
        else n_pass++;
        bus.d_req = 1'b0;
      end
      if (c == 9) begin
        n_checks++;
        if (bus.rdata !== init_val(8'h30))
          $display("FAIL contend_i_rdata: got %h want %h", bus.rdata, init_val(8'h30));
        else n_pass++;
        bus.i_req = 1'b0;
      end
      #1;
      n_checks++;
      if ({bus.i_stall, bus.d_stall} !== {c <= 8, c <= 3})
        $display("FAIL contend_stall c%0d: got %b want %b", c,
                 {bus.i_stall, bus.d_stall}, {c <= 8, c <= 3});
      else n_pass++;
    end
  endtask

  task automatic test_unaligned();
    logic [4:0] exp;
    do_reset();
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0003;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      exp = {1'b0, 1'b0, c == 1, c == 1, c == 1};
      n_checks++;
      if ({bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy} !== exp)
        $display("FAIL unaligned_ctrl c%0d: got %b want %b", c,
                 {bus.mem_en, bus.i_done, bus.d_done, bus.err, bus.busy}, exp);
      else n_pass++;
      if (c == 1) bus.d_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    tick();
    tick();
    rst       = 1'b1;
    bus.i_req = 1'b0;
    tick();
    n_checks++;
    if ({bus.mem_en, bus.busy, bus.i_done, bus.d_done, bus.err, bus.createdump,
         bus.mem_addr, bus.rdata} !== '0)
      $display("FAIL midreset_clear: busy %b mem_en %b addr %h", bus.busy, bus.mem_en, bus.mem_addr);
    else n_pass++;
    rst = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      tick();
      n_checks++;
      if ({bus.i_done, bus.busy, bus.mem_en} !== 3'b000)
        $display("FAIL midreset_quiet c%0d: got %b want 000", c, {bus.i_done, bus.busy, bus.mem_en});
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    logic [4:0] exp;
    do_reset();
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0040;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) tick();
      exp = {c == 1, c == 6, 1'b0, c == 4, ((c >= 1 && c <= 4) || c >= 6)};
      n_checks++;
      if ({bus.mem_en, bus.createdump, bus.i_done, bus.d_done, bus.busy} !== exp)
        $display("FAIL halt_ctrl c%0d: got %b want %b", c,
                 {bus.mem_en, bus.createdump, bus.i_done, bus.d_done, bus.busy}, exp);
      else n_pass++;
      if (c == 2) bus.halt = 1'b1;
      if (c == 4) bus.d_req = 1'b0;
      if (c == 8) begin
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0010;
      end
    end
    do_reset();
    tick();
    n_checks++;
    if ({bus.busy, bus.createdump} !== 2'b00)
      $display("FAIL halt_exit: got %b want 00", {bus.busy, bus.createdump});
    else n_pass++;
  endtask

  // Randomized traffic against a transaction-level model: grant at the first free
  // cycle with a pending request (data first); done after LAT+2 cycles, or 1 if unaligned.
  task automatic test_random();
    bit          i_pend, d_pend, act, act_d, act_wr, act_err, just_i, just_d;
    int          f_cyc, act_start, act_done;
    logic [15:0] act_addr, act_wdata, act_rd, a;
    logic [5:0]  got, exp;
    do_reset();
    for (int k = 0; k < 256; k++) ref_mem[k] = init_val(8'(k));
    i_pend = 0; d_pend = 0; act = 0; f_cyc = 0;
    act_d = 0; act_wr = 0; act_err = 0; act_start = 0; act_done = 0;
    act_addr = '0; act_wdata = '0; act_rd = '0;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) tick();
      exp = {act && !act_d && c == act_done, act && act_d && c == act_done,
             act && act_err && c == act_done, act && !act_err && c == act_start + 1,
             1'b0, act && c > act_start && c <= act_done};
      got = {bus.i_done, bus.d_done, bus.err, bus.mem_en, bus.createdump, bus.busy};
      n_checks++;
      if (got !== exp) $display("FAIL rand_ctrl c%0d: got %b want %b", c, got, exp);
      else n_pass++;
      if (exp[2]) begin
        n_checks++;
        if ({bus.mem_wr, bus.mem_addr} !== {act_wr, act_addr} ||
            (act_wr && bus.mem_wdata !== act_wdata))
          $display("FAIL rand_port c%0d: got %b %h %h want %b %h %h", c, bus.mem_wr,
                   bus.mem_addr, bus.mem_wdata, act_wr, act_addr, act_wdata);
        else n_pass++;
      end
      just_i = 0;
      just_d = 0;
      if (act && c == act_done) begin
        if (!act_err && !act_wr) begin
          n_checks++;
          if (bus.rdata !== act_rd) $display("FAIL rand_rdata c%0d: got %h want %h", c, bus.rdata, act_rd);
          else n_pass++;
        end
        act = 0;
        if (act_d) begin d_pend = 0; just_d = 1; bus.d_req = 1'b0; end
        else       begin i_pend = 0; just_i = 1; bus.i_req = 1'b0; end
      end
      if (!i_pend && !just_i && $urandom_range(0, 3) == 0) begin
        a = 16'($urandom_range(0, 127)) & 16'hFFFE;
        if ($urandom_range(0, 7) == 0) a = a | 16'h0001;
        bus.i_req = 1'b1; bus.i_addr = a; i_pend = 1;
      end
      if (!d_pend && !just_d && $urandom_range(0, 3) == 0) begin
        a = 16'($urandom_range(0, 127)) & 16'hFFFE;
        if ($urandom_range(0, 7) == 0) a = a | 16'h0001;
        bus.d_req = 1'b1; bus.d_addr = a; bus.d_wr = 1'($urandom_range(0, 1));
        bus.d_wdata = 16'($urandom); d_pend = 1;
      end
      if (!act && c >= f_cyc && (i_pend || d_pend)) begin
        act       = 1;
        act_d     = d_pend;
        act_addr  = d_pend ? bus.d_addr : bus.i_addr;
        act_wr    = d_pend && bus.d_wr;
        act_wdata = bus.d_wdata;
        act_err   = act_addr[0];
        act_start = c;
        act_done  = c + (act_err ? 1 : int'(LAT) + 2);
        f_cyc     = act_done + 1;
        if (!act_err) begin
          if (act_wr) ref_mem[act_addr[7:0]] = act_wdata;
          else act_rd = ref_mem[act_addr[7:0]];
        end
      end
      #1;
      n_checks++;
      if ({bus.i_stall, bus.d_stall} !== {i_pend, d_pend})
        $display("FAIL rand_stall c%0d: got %b want %b", c, {bus.i_stall, bus.d_stall}, {i_pend, d_pend});
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_data_write();
    test_contention();
    test_unaligned();
    test_random();
    test_reset_mid_access();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
